activity_led_ctrl: RTL
======================

ACTIVITY_LED_CTRL -- requirements
Module: activity_led_ctrl

Interface
REQ-001 SHALL have parameter N_CH, 4, number of detector inputs (1..8).
REQ-002 SHALL have parameter N_LED, 2, number of LED outputs (1..32).
REQ-003 SHALL have parameter HOLD_W, 20, width of stretch counter.
REQ-004 SHALL have parameter HOLD_CYCLES, 2**HOLD_W-1, stretch duration in clocks (1..2**HOLD_W-1).
REQ-005 SHALL have one clock; reset is synchronous and active-low.
REQ-006 SHALL have port fx2_clk  input  1  sole clock, all state on rising edge.
REQ-007 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-008 SHALL have port detectors  input  N_CH  asynchronous detector pulses.
REQ-009 SHALL have port cmd_wr  input  1  one-cycle strobe, cmd_in valid.
REQ-010 SHALL have port cmd_in  input  8  command byte.
REQ-011 SHALL have port led  output  N_LED  LED drive, registered.
REQ-012 SHALL have port cfg_busy  output  1  high while a command is half-received.

Function
REQ-013 SHALL pass each detector bit through a 2-flop synchroniser, then a rising-edge detector (one-cycle event per 0->1).
REQ-014 SHALL, for LED i, form hit_i = OR over (event AND mask_i); mask_i is N_CH bits.
REQ-015 SHALL support per-LED mode: 00 OFF (led=0), 01 STRETCH, 10 TOGGLE, 11 ON (led=1).
REQ-016 STRETCH: hit loads counter with HOLD_CYCLES; led=1 while counter nonzero; counter decrements by 1 per cycle, saturates at 0.
REQ-017 STRETCH retrigger: hit while counter nonzero reloads HOLD_CYCLES (no accumulation, no wrap).
REQ-018 TOGGLE: each hit inverts led; simultaneous events on several masked channels in one cycle count as one hit.
REQ-019 Latency: detector rising at input before edge k SHALL give led change visible after edge k+3 (2 sync + edge + output register).
REQ-020 Command parser FSM states IDLE, WAIT_MASK; cmd_wr ignored when 0.
REQ-021 IDLE: byte with bit7=1 is header (bits[6:5]=mode, bits[4:0]=LED index) -> latch, go WAIT_MASK; bit7=0 ignored, stay IDLE.
REQ-022 WAIT_MASK: next byte (any value) supplies mask = byte[N_CH-1:0] -> go IDLE; if index < N_LED commit mode+mask for that LED, else discard.
REQ-023 Commit SHALL take effect the cycle after the mask byte; committed LED's counter cleared and toggle state cleared to 0.
REQ-024 Commit with mask=0 in STRETCH/TOGGLE SHALL hold led at 0 (no hits possible).
REQ-025 cfg_busy SHALL equal (state==WAIT_MASK), registered.
REQ-026 Event coinciding with commit cycle SHALL be evaluated against the old configuration; the commit then clears counter/toggle.
REQ-027 Non-addressed LEDs SHALL be unaffected by any command.

Reset
REQ-028 rst_n low at a clock edge SHALL set: FSM IDLE, cfg_busy 0, led all 0, counters 0, toggle states 0, synchroniser/edge flops 0.
REQ-029 Reset SHALL set every LED to mode STRETCH, mask all ones (OR-of-all-detectors behaviour).
REQ-030 Reset during WAIT_MASK SHALL discard the pending header; no partial commit.
REQ-031 First event after reset release SHALL require a 0->1 transition seen after the synchroniser refills; a detector held high through reset produces no event.

Structure
REQ-032 Shared package SHALL hold mode enum (OFF, STRETCH, TOGGLE, ON), header bit positions (HDR_FLAG=7, MODE_MSB=6, MODE_LSB=5, IDX_MSB=4), parser state enum.
REQ-033 Per-LED counter/toggle/output logic SHALL be one sub-module, led_stretch_cell, instantiated N_LED times via generate.
REQ-034 Synchroniser, edge detect and parser SHALL live in activity_led_ctrl itself.

Verification
REQ-035 Post-reset, HOLD_CYCLES=10, pulse detectors[2] one cycle -> led=2'b11 from edge k+3 for exactly 10 cycles, then 0.
REQ-036 STRETCH retrigger: second pulse 5 cycles after first -> led high 15 cycles total from first assertion.
REQ-037 Commands 0xC1,0x01 (LED1 TOGGLE mask ch0) -> cfg_busy high 1 cycle; 3 pulses on ch0 -> led[1] 1,0,1; ch1 pulses leave led[1] unchanged.
REQ-038 Header 0xBF (index 31 with N_LED=2), then 0x0F -> FSM back to IDLE, no LED config changes; byte 0x05 in IDLE -> ignored.
REQ-039 Header 0xE0 (LED0 ON) then assert rst_n low before mask byte -> LED0 remains STRETCH, all-ones mask, cfg_busy 0.
REQ-040 Pulses on ch0 and ch3 in same cycle, LED0 TOGGLE mask 0x09 -> led[0] toggles once.

Source files
------------

// File: rtl/activity_led_ctrl_pkg.sv
// Shared types for the activity LED controller: LED modes, parser states and
// command header layout.
package activity_led_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_STRETCH = 2'b01,
    MODE_TOGGLE  = 2'b10,
    MODE_ON      = 2'b11
  } led_mode_e;

  typedef enum logic {
    PS_IDLE      = 1'b0,
    PS_WAIT_MASK = 1'b1
  } parse_state_e;

  localparam int HDR_FLAG = 7;
  localparam int MODE_MSB = 6;
  localparam int MODE_LSB = 5;
  localparam int IDX_MSB  = 4;
  localparam int IDX_W    = IDX_MSB + 1;

  typedef struct packed {
    led_mode_e        mode;
    logic [IDX_W-1:0] idx;
  } hdr_t;

  // Fields below the header flag: mode and target LED index.
  function automatic hdr_t decode_hdr(input logic [MODE_MSB:0] b);
    hdr_t h;
    h.mode = led_mode_e'(b[MODE_MSB:MODE_LSB]);
    h.idx  = b[IDX_MSB:0];
    return h;
  endfunction

endpackage

// File: rtl/activity_led_ctrl_cell.sv
// One LED: stretch counter, toggle state and registered drive, selected by mode.
module led_stretch_cell
  import activity_led_ctrl_pkg::*;
#(
  parameter int HOLD_W      = 20,
  parameter int HOLD_CYCLES = 2**HOLD_W-1
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      hit,
  input  logic      clr,
  input  led_mode_e mode,
  input  led_mode_e commit_mode,
  output logic      led
);

  localparam logic [HOLD_W-1:0] HOLD_LD = HOLD_W'(HOLD_CYCLES);

  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic              tog_q, tog_d;
  logic              led_d;

  always_comb begin
    cnt_d = cnt_q;
    tog_d = tog_q;
    led_d = 1'b0;
    // A commit overrides whatever the old configuration did this cycle.
    if (clr) begin
      cnt_d = '0;
      tog_d = 1'b0;
      led_d = (commit_mode == MODE_ON);
    end else begin
      unique case (mode)
        MODE_OFF: led_d = 1'b0;
        MODE_STRETCH: begin
          if (hit)                cnt_d = HOLD_LD;
          else if (cnt_q != '0)   cnt_d = cnt_q - 1'b1;
          led_d = (cnt_d != '0);
        end
        MODE_TOGGLE: begin
          tog_d = tog_q ^ hit;
          led_d = tog_d;
        end
        MODE_ON: led_d = 1'b1;
        default: led_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      tog_q <= 1'b0;
      led   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tog_q <= tog_d;
      led   <= led_d;
    end
  end

endmodule

// File: rtl/activity_led_ctrl.sv
// Activity LED controller: synchronised detector edges drive per-LED
// stretch/toggle cells, configured through a two-byte command stream.
module activity_led_ctrl
  import activity_led_ctrl_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int N_LED       = 2,
  parameter int HOLD_W      = 20,
  parameter int HOLD_CYCLES = 2**HOLD_W-1
) (
  input  logic             fx2_clk,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  detectors,
  input  logic             cmd_wr,
  input  logic [7:0]       cmd_in,
  output logic [N_LED-1:0] led,
  output logic             cfg_busy
);

  localparam int SYNC_STAGES = 2;

  logic [N_CH-1:0]        sync1_q, sync2_q, prev_q, evt_q;
  logic [SYNC_STAGES:0]   vld_pipe;

  // Edges are only trusted once sync2 and prev both hold post-reset samples,
  // so a detector held high through reset never fires.
  always_ff @(posedge fx2_clk) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      prev_q   <= '0;
      evt_q    <= '0;
      vld_pipe <= '0;
    end else begin
      sync1_q  <= detectors;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      vld_pipe <= {vld_pipe[SYNC_STAGES-1:0], 1'b1};
      evt_q    <= sync2_q & ~prev_q & {N_CH{vld_pipe[SYNC_STAGES]}};
    end
  end

  parse_state_e state_q, state_d;
  hdr_t         hdr_q, hdr_d;
  logic         commit;

  always_ff @(posedge fx2_clk) begin
    if (!rst_n) begin
      state_q <= PS_IDLE;
      hdr_q   <= '0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hdr_d   = hdr_q;
    commit  = 1'b0;
    unique case (state_q)
      PS_IDLE: begin
        if (cmd_wr && cmd_in[HDR_FLAG]) begin
          hdr_d   = decode_hdr(cmd_in[MODE_MSB:0]);
          state_d = PS_WAIT_MASK;
        end
      end
      PS_WAIT_MASK: begin
        if (cmd_wr) begin
          commit  = 1'b1;
          state_d = PS_IDLE;
        end
      end
      default: state_d = PS_IDLE;
    endcase
  end

  assign cfg_busy = (state_q == PS_WAIT_MASK);

  // Out-of-range indices match no cell, so such a commit is simply dropped.
  for (genvar i = 0; i < N_LED; i++) begin : g_led
    led_mode_e       mode_q;
    logic [N_CH-1:0] mask_q;
    logic            clr, hit;

    assign clr = commit && (hdr_q.idx == IDX_W'(i));
    assign hit = |(evt_q & mask_q);

    always_ff @(posedge fx2_clk) begin
      if (!rst_n) begin
        mode_q <= MODE_STRETCH;
        mask_q <= '1;
      end else if (clr) begin
        mode_q <= hdr_q.mode;
        mask_q <= cmd_in[N_CH-1:0];
      end
    end

    led_stretch_cell #(
      .HOLD_W      (HOLD_W),
      .HOLD_CYCLES (HOLD_CYCLES)
    ) u_cell (
      .clk         (fx2_clk),
      .rst_n       (rst_n),
      .hit         (hit),
      .clr         (clr),
      .mode        (mode_q),
      .commit_mode (hdr_q.mode),
      .led         (led[i])
    );
  end

endmodule
